// File: rtl/code_mult2_pkg.sv
// Shared constants for the code_mult2 array multiplier.
package code_mult2_pkg;
    localparam int unsigned CM2_DEF_WIDTH = 2;
    localparam int unsigned CM2_MIN_WIDTH = 2;
    localparam int unsigned CM2_MAX_WIDTH = 8;
endpackage

// File: rtl/code_mult2_full_adder.sv
// One-bit full adder cell; tie cin to 0 to use it as a half adder.
module code_mult2_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/code_mult2.sv
// Unsigned WIDTH x WIDTH array multiplier (AND array + ripple adder rows)
// with a one-stage registered copy of the product and a valid flag.
module code_mult2
    import code_mult2_pkg::*;
#(
    parameter int unsigned WIDTH = CM2_DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               in_valid,
    output logic [2*WIDTH-1:0] product,
    output logic [2*WIDTH-1:0] product_q,
    output logic               out_valid
);
    logic [WIDTH-1:0][WIDTH-1:0] pp;   // pp[i][j] = a[j] & b[i]
    logic [WIDTH-1:0][WIDTH-1:0] up;   // running upper bits after each row
    logic [WIDTH-1:1][WIDTH-1:0] sm;
    logic [WIDTH-1:1][WIDTH:0]   cy;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp_row
        for (genvar j = 0; j < WIDTH; j++) begin : g_pp_col
            assign pp[i][j] = a[j] & b[i];
        end
    end

    // Row 0: bit 0 is final; the rest becomes the upper operand of row 1.
    assign product[0] = pp[0][0];
    assign up[0]      = {1'b0, pp[0][WIDTH-1:1]};

    // Each row adds pp[i] to the upper bits so far; its LSB retires as product[i].
    for (genvar i = 1; i < WIDTH; i++) begin : g_row
        assign cy[i][0] = 1'b0;
        for (genvar j = 0; j < WIDTH; j++) begin : g_col
            code_mult2_full_adder u_fa (
                .a    (pp[i][j]),
                .b    (up[i-1][j]),
                .cin  (cy[i][j]),
                .s    (sm[i][j]),
                .cout (cy[i][j+1])
            );
        end
        assign product[i] = sm[i][0];
        assign up[i]      = {cy[i][WIDTH], sm[i][WIDTH-1:1]};
    end

    assign product[2*WIDTH-1:WIDTH] = up[WIDTH-1];

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               vld_q, vld_d;

    always_comb begin
        prod_d = prod_q;
        vld_d  = in_valid;
        if (in_valid) prod_d = product;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
        end
    end

    assign product_q = prod_q;
    assign out_valid = vld_q;
endmodule

// File: tb/tb_code_mult2.sv
// Self-checking bench for code_mult2 at WIDTH=2 and WIDTH=8 against plain a*b.
module tb_code_mult2;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  a2, b2;
    logic [7:0]  a8, b8;
    logic [3:0]  product2, product_q2;
    logic [15:0] product8, product_q8;
    logic        out_valid2, out_valid8;

    int checks = 0;
    int errors = 0;
    logic [15:0] e2q, e8q;

    always #5 clk = ~clk;

    code_mult2 #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .in_valid(in_valid),
        .product(product2), .product_q(product_q2), .out_valid(out_valid2)
    );

    code_mult2 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(in_valid),
        .product(product8), .product_q(product_q8), .out_valid(out_valid8)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on both instances, check comb output, then the register stage.
    task automatic step(input logic [1:0] a2i, input logic [1:0] b2i,
                        input logic [7:0] a8i, input logic [7:0] b8i, input logic iv);
        @(negedge clk);
        a2 = a2i; b2 = b2i; a8 = a8i; b8 = b8i; in_valid = iv;
        #1;
        check("product2", {12'd0, product2}, 16'(a2i) * 16'(b2i));
        check("product8", product8, 16'(a8i) * 16'(b8i));
        @(posedge clk);
        #1;
        if (iv) begin
            e2q = 16'(a2i) * 16'(b2i);
            e8q = 16'(a8i) * 16'(b8i);
        end
        check("product_q2", {12'd0, product_q2}, e2q);
        check("out_valid2", {15'd0, out_valid2}, {15'd0, iv});
        check("product_q8", product_q8, e8q);
        check("out_valid8", {15'd0, out_valid8}, {15'd0, iv});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0;
        a2 = 2'd0; b2 = 2'd0; a8 = 8'd0; b8 = 8'd0;
        e2q = '0; e8q = '0;
        #12;
        check("rst_product_q2", {12'd0, product_q2}, 16'd0);
        check("rst_out_valid2", {15'd0, out_valid2}, 16'd0);
        check("rst_product_q8", product_q8, 16'd0);
        check("rst_out_valid8", {15'd0, out_valid8}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed points from the test plan.
        step(2'd2, 2'd3, 8'd255, 8'd255, 1'b1);
        step(2'd1, 2'd1, 8'd1,   8'd0,   1'b1);
        step(2'd3, 2'd3, 8'd128, 8'd2,   1'b1);
        step(2'd0, 2'd0, 8'd7,   8'd9,   1'b0);

        @(negedge clk);
        a2 = 2'd0; b2 = 2'd2;
        #10 check("p2_0x2", {12'd0, product2}, 16'd0);
        a2 = 2'd2; b2 = 2'd2;
        #10 check("p2_2x2", {12'd0, product2}, 16'd4);

        // Exhaustive WIDTH=2 sweep alongside random WIDTH=8 operands.
        for (int i = 0; i < 16; i++)
            step(2'(i >> 2), 2'(i), 8'($urandom), 8'($urandom), 1'b1);

        // Random sweep with random gaps in in_valid.
        for (int i = 0; i < 200; i++)
            step(2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 3) != 0));

        // Asynchronous reset mid-stream while in_valid is high.
        step(2'd3, 2'd2, 8'd200, 8'd100, 1'b1);
        @(negedge clk);
        a2 = 2'd3; b2 = 2'd1; a8 = 8'd17; b8 = 8'd19; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_product_q2", {12'd0, product_q2}, 16'd0);
        check("arst_out_valid2", {15'd0, out_valid2}, 16'd0);
        check("arst_product_q8", product_q8, 16'd0);
        check("arst_out_valid8", {15'd0, out_valid8}, 16'd0);
        check("arst_product2", {12'd0, product2}, 16'd3);
        @(posedge clk);
        #1;
        check("arst_hold_q8", product_q8, 16'd0);
        check("arst_hold_v8", {15'd0, out_valid8}, 16'd0);
        a8 = 8'd250; b8 = 8'd3;
        #1 check("arst_product8", product8, 16'd750);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        e2q = '0; e8q = '0;
        step(2'd1, 2'd3, 8'd12, 8'd12, 1'b0);
        step(2'd2, 2'd1, 8'd99, 8'd101, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
